// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage of the pipelined RV32I core: PC register, next-PC selection and the
// IF/ID pipeline register. Redirects fetch on taken branches, JAL and JALR
// (PCSrcE from the EX-stage branch controller) and squashes the wrong-path
// instruction held in D. Also keeps a sticky misaligned-target flag and a
// saturating redirect counter for debug.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          synchronous active-high reset
//   PCSrcE[1:0]  00 sequential, 01 PC-relative target, 10 JALR target, 11 reserved
//   PCTargetE    PCE+ImmExtE computed in EX
//   ALUResultE   rs1+imm from the EX ALU (JALR target)
//   StallF       hold PC
//   StallD       hold IF/ID register
//   FlushD       external flush of IF/ID register
//   InstrF       instruction memory read data for PCF
//   PCF          current fetch address
//   InstrD       IF/ID instruction
//   PCD          IF/ID PC
//   PCPlus4D     IF/ID PC+4
//   ValidD       IF/ID holds a real (non-bubble) instruction
//   RedirectE    combinational: PCSrcE selects a redirect target
//   MisalignF    sticky: a redirect target had bit[1] set
//   RedirectCnt  number of redirects taken, saturating
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       PCSrcE,
   input  logic [31:0]      PCTargetE,
   input  logic [31:0]      ALUResultE,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic [31:0]      InstrF,
   output logic [31:0]      PCF,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCD,
   output logic [31:0]      PCPlus4D,
   output logic             ValidD,
   output logic             RedirectE,
   output logic             MisalignF,
   output logic [CNT_W-1:0] RedirectCnt
);

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] SRC_PCREL = 2'b01;
   localparam logic [1:0] SRC_JALR  = 2'b10;

   logic            redirect;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_next;
   logic            flush_d;
   logic            cnt_full;

   // Sequential successor; wraps modulo 2^32.
   always_comb begin
      pc_plus4 = PCF + XLEN'(4);
   end

   // 11 is reserved and behaves exactly like sequential fetch.
   always_comb begin
      redirect = (PCSrcE == SRC_PCREL) | (PCSrcE == SRC_JALR);
   end

   assign RedirectE = redirect;

   // JALR clears the target LSB; PC-relative targets pass through untouched.
   always_comb begin
      target = PCTargetE;
      if (PCSrcE == SRC_JALR) begin
         target = ALUResultE & ~XLEN'(1);
      end
   end

   // A redirect must win over StallF, otherwise the taken target is lost.
   always_comb begin
      pc_next = pc_plus4;
      if (redirect) begin
         pc_next = target;
      end else if (StallF) begin
         pc_next = PCF;
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (rst) begin
         PCF <= RESET_PC;
      end else begin
         PCF <= pc_next;
      end
   end

   // The instruction currently in F is wrong-path whenever EX redirects.
   always_comb begin
      flush_d = FlushD | redirect;
   end

   // IF/ID pipeline register; flush beats stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (flush_d) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         InstrD   <= InstrF;
         PCD      <= PCF;
         PCPlus4D <= pc_plus4;
         ValidD   <= 1'b1;
      end
   end

   // Sticky misaligned-target flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         MisalignF <= 1'b0;
      end else if (redirect && target[1]) begin
         MisalignF <= 1'b1;
      end
   end

   always_comb begin
      cnt_full = (RedirectCnt == {CNT_W{1'b1}});
   end

   // Saturating redirect counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         RedirectCnt <= '0;
      end else if (redirect && !cnt_full) begin
         RedirectCnt <= RedirectCnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural model predicts the state
// after each clock edge; predictions are queued before the edge and popped and
// compared after it. Scenario tasks add directed checks against fixed values.
// A second instance with CNT_W=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] IMASK = 32'h5A5A_0000;

   logic        clk;
   logic        rst;
   logic [1:0]  src;
   logic [31:0] ptgt;
   logic [31:0] alu;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic [31:0] instr_f;
   logic [31:0] pcf;
   logic [31:0] instr_d;
   logic [31:0] pcd;
   logic [31:0] pc4d;
   logic        valid_d;
   logic        redirect_e;
   logic        mis;
   logic [15:0] cnt;

   logic [31:0] instr_f2;
   logic [31:0] pcf2;
   logic [31:0] instr_d2;
   logic [31:0] pcd2;
   logic [31:0] pc4d2;
   logic        valid_d2;
   logic        redirect_e2;
   logic        mis2;
   logic [1:0]  cnt2;

   int checks = 0;
   int errors = 0;

   // Instruction memory: combinational, data derived from the address.
   assign instr_f  = pcf  ^ IMASK;
   assign instr_f2 = pcf2 ^ IMASK;

   fetch_stage u_dut (
      .clk(clk), .rst(rst), .PCSrcE(src), .PCTargetE(ptgt), .ALUResultE(alu),
      .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d), .InstrF(instr_f),
      .PCF(pcf), .InstrD(instr_d), .PCD(pcd), .PCPlus4D(pc4d), .ValidD(valid_d),
      .RedirectE(redirect_e), .MisalignF(mis), .RedirectCnt(cnt)
   );

   fetch_stage #(.CNT_W(2)) u_cnt2 (
      .clk(clk), .rst(rst), .PCSrcE(src), .PCTargetE(ptgt), .ALUResultE(alu),
      .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d), .InstrF(instr_f2),
      .PCF(pcf2), .InstrD(instr_d2), .PCD(pcd2), .PCPlus4D(pc4d2), .ValidD(valid_d2),
      .RedirectE(redirect_e2), .MisalignF(mis2), .RedirectCnt(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pcd;
      logic [31:0] pc4d;
      logic        valid;
      logic        mis;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t sb_q[$];

   // Model state
   logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
   logic        m_valid, m_mis;
   logic [15:0] m_cnt;
   logic [1:0]  m_cnt2;

   // Predict the next state from current inputs, push it, clock, pop, compare.
   task automatic step(input string tag);
      exp_t        e;
      logic        redir;
      logic [31:0] tgt;
      logic [31:0] pc4;
      #1;
      redir = (src == 2'b01) || (src == 2'b10);
      checks++;
      if (redirect_e !== redir) begin
         errors++;
         $display("FAIL %s redirect_e: got %0b expected %0b", tag, redirect_e, redir);
      end
      tgt = (src == 2'b10) ? {alu[31:1], 1'b0} : ptgt;
      pc4 = m_pc + 32'd4;
      if (rst) begin
         m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0;
         m_valid = 1'b0; m_mis = 1'b0; m_cnt = 16'h0; m_cnt2 = 2'h0;
      end else begin
         if (flush_d || redir) begin
            m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
         end else if (!stall_d) begin
            m_instr = m_pc ^ IMASK; m_pcd = m_pc; m_pc4d = pc4; m_valid = 1'b1;
         end
         if (redir) m_pc = tgt;
         else if (!stall_f) m_pc = pc4;
         if (redir && tgt[1]) m_mis = 1'b1;
         if (redir && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (redir && m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
      end
      sb_q.push_back('{m_pc, m_instr, m_pcd, m_pc4d, m_valid, m_mis, m_cnt, m_cnt2});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (pcf !== e.pc) begin
         errors++; $display("FAIL %s PCF: got %08h expected %08h", tag, pcf, e.pc);
      end
      checks++;
      if (instr_d !== e.instr) begin
         errors++; $display("FAIL %s InstrD: got %08h expected %08h", tag, instr_d, e.instr);
      end
      checks++;
      if (pcd !== e.pcd) begin
         errors++; $display("FAIL %s PCD: got %08h expected %08h", tag, pcd, e.pcd);
      end
      checks++;
      if (pc4d !== e.pc4d) begin
         errors++; $display("FAIL %s PCPlus4D: got %08h expected %08h", tag, pc4d, e.pc4d);
      end
      checks++;
      if (valid_d !== e.valid) begin
         errors++; $display("FAIL %s ValidD: got %0b expected %0b", tag, valid_d, e.valid);
      end
      checks++;
      if (mis !== e.mis) begin
         errors++; $display("FAIL %s MisalignF: got %0b expected %0b", tag, mis, e.mis);
      end
      checks++;
      if (cnt !== e.cnt) begin
         errors++; $display("FAIL %s RedirectCnt: got %0d expected %0d", tag, cnt, e.cnt);
      end
      checks++;
      if (cnt2 !== e.cnt2) begin
         errors++; $display("FAIL %s RedirectCnt(W=2): got %0d expected %0d", tag, cnt2, e.cnt2);
      end
   endtask

   task automatic idle_inputs();
      src = 2'b00; ptgt = 32'h0; alu = 32'h0;
      stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step("reset");
      step("reset2");
      checks++;
      if (pcf !== 32'h0 || instr_d !== NOP || valid_d !== 1'b0 || cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_values: PCF=%08h InstrD=%08h ValidD=%0b Cnt=%0d required 0/00000013/0/0",
                  pcf, instr_d, valid_d, cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      step("seq0");
      checks++;
      if (pcf !== 32'h4 || instr_d !== (32'h0 ^ IMASK) || valid_d !== 1'b1) begin
         errors++;
         $display("FAIL seq_first: PCF=%08h InstrD=%08h ValidD=%0b required 4/%08h/1",
                  pcf, instr_d, valid_d, IMASK);
      end
      step("seq1");
      step("seq2");
      checks++;
      if (pcf !== 32'hC || pcd !== 32'h8 || pc4d !== 32'hC) begin
         errors++;
         $display("FAIL seq_third: PCF=%08h PCD=%08h PCPlus4D=%08h required C/8/C", pcf, pcd, pc4d);
      end
   endtask

   task automatic test_branch();
      rst = 1'b1; step("br_rst"); rst = 1'b0;
      step("br_a"); step("br_b");
      src = 2'b01; ptgt = 32'h100;
      step("branch");
      src = 2'b00;
      checks++;
      if (pcf !== 32'h100 || instr_d !== NOP || valid_d !== 1'b0 || cnt !== 16'd1) begin
         errors++;
         $display("FAIL branch_redirect: PCF=%08h InstrD=%08h ValidD=%0b Cnt=%0d required 100/00000013/0/1",
                  pcf, instr_d, valid_d, cnt);
      end
      step("branch_after");
      checks++;
      if (pcd !== 32'h100 || valid_d !== 1'b1) begin
         errors++;
         $display("FAIL branch_target_in_d: PCD=%08h ValidD=%0b required 100/1", pcd, valid_d);
      end
   endtask

   task automatic test_jalr_misalign();
      src = 2'b10; alu = 32'h203;
      step("jalr");
      src = 2'b00;
      checks++;
      if (pcf !== 32'h202 || mis !== 1'b1) begin
         errors++;
         $display("FAIL jalr_target: PCF=%08h MisalignF=%0b required 202/1", pcf, mis);
      end
      for (int i = 0; i < 10; i++) step("mis_hold");
      checks++;
      if (mis !== 1'b1) begin
         errors++; $display("FAIL mis_sticky: MisalignF=%0b required 1", mis);
      end
   endtask

   task automatic test_stall();
      src = 2'b01; ptgt = 32'h3C;
      step("st_redir");
      src = 2'b00;
      step("st_load");
      stall_f = 1'b1; stall_d = 1'b1;
      for (int i = 0; i < 3; i++) step("stall");
      checks++;
      if (pcf !== 32'h40 || pcd !== 32'h3C || instr_d !== (32'h3C ^ IMASK)) begin
         errors++;
         $display("FAIL stall_hold: PCF=%08h PCD=%08h InstrD=%08h required 40/3C/%08h",
                  pcf, pcd, instr_d, 32'h3C ^ IMASK);
      end
      src = 2'b01; ptgt = 32'h80;
      step("redir_over_stall");
      checks++;
      if (pcf !== 32'h80 || valid_d !== 1'b0 || instr_d !== NOP) begin
         errors++;
         $display("FAIL redir_over_stall: PCF=%08h ValidD=%0b InstrD=%08h required 80/0/00000013",
                  pcf, valid_d, instr_d);
      end
      idle_inputs();
      step("st_resume");
   endtask

   task automatic test_flush();
      flush_d = 1'b1; stall_d = 1'b1;
      step("flush_over_stall");
      checks++;
      if (valid_d !== 1'b0 || pcd !== 32'h0 || pcf !== 32'h88) begin
         errors++;
         $display("FAIL flush_over_stall: ValidD=%0b PCD=%08h PCF=%08h required 0/0/88", valid_d, pcd, pcf);
      end
      idle_inputs();
      step("fl_resume");
   endtask

   task automatic test_reserved_wrap();
      logic [15:0] c0;
      c0 = cnt;
      src = 2'b11; ptgt = 32'h500; alu = 32'h603;
      step("rsv0");
      step("rsv1");
      checks++;
      if (cnt !== c0 || valid_d !== 1'b1 || pcf !== 32'h94) begin
         errors++;
         $display("FAIL reserved_src: Cnt=%0d ValidD=%0b PCF=%08h required %0d/1/94", cnt, valid_d, pcf, c0);
      end
      src = 2'b01; ptgt = 32'hFFFF_FFF8;
      step("wrap_redir");
      src = 2'b00;
      step("wrap_fc");
      step("wrap_0");
      checks++;
      if (pcf !== 32'h0 || pcd !== 32'hFFFF_FFFC || pc4d !== 32'h0) begin
         errors++;
         $display("FAIL pc_wrap: PCF=%08h PCD=%08h PCPlus4D=%08h required 0/FFFFFFFC/0", pcf, pcd, pc4d);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp2 [5];
      exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
      rst = 1'b1; step("b2b_rst"); rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         src = 2'b01; ptgt = 32'h1000 + 32'(i * 16);
         step("b2b");
         checks++;
         if (cnt2 !== exp2[i] || valid_d !== 1'b0 || pcf !== 32'h1000 + 32'(i * 16)) begin
            errors++;
            $display("FAIL b2b_%0d: Cnt2=%0d ValidD=%0b PCF=%08h required %0d/0/%08h",
                     i, cnt2, valid_d, pcf, exp2[i], 32'h1000 + 32'(i * 16));
         end
      end
      checks++;
      if (cnt !== 16'd5) begin
         errors++; $display("FAIL b2b_cnt16: Cnt=%0d required 5", cnt);
      end
      src = 2'b10; alu = 32'h2222; rst = 1'b1;
      step("rst_mid");
      checks++;
      if (pcf !== 32'h0 || instr_d !== NOP || valid_d !== 1'b0 || cnt !== 16'h0
          || cnt2 !== 2'h0 || mis !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: PCF=%08h InstrD=%08h ValidD=%0b Cnt=%0d Cnt2=%0d Mis=%0b required reset values",
                  pcf, instr_d, valid_d, cnt, cnt2, mis);
      end
      rst = 1'b0; idle_inputs();
      step("post_rst0");
      step("post_rst1");
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_sequential();
      test_branch();
      test_jalr_misalign();
      test_stall();
      test_flush();
      test_reserved_wrap();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
